// File: rtl/uart_pkg.sv
// Shared constants, FSM state encoding and STATUS word packing for the
// memory-mapped UART transmitter.
package uart_pkg;

    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    localparam int ST_FULL = 0;
    localparam int ST_IDLE = 1;
    localparam int ST_OVF  = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    function automatic logic [31:0] status_word(input logic ovf, input logic idle, input logic full);
        logic [31:0] w;
        w          = 32'h0000_0000;
        w[ST_OVF]  = ovf;
        w[ST_IDLE] = idle;
        w[ST_FULL] = full;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Core-side IO bus for the UART transmitter: single-cycle strobes, register
// select, store data and registered read data.
interface uart_tx_mmio_if;
    logic        io_wr;
    logic        io_rd;
    logic        io_reg;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;

    modport master (
        output io_wr,
        output io_rd,
        output io_reg,
        output io_wdata,
        input  io_rdata
    );

    modport slave (
        input  io_wr,
        input  io_rd,
        input  io_reg,
        input  io_wdata,
        output io_rdata
    );
endinterface

// File: rtl/uart_fifo.sv
// Show-ahead synchronous FIFO; pushes into a full FIFO and pops from an empty
// one are ignored, and full/empty come from the registered count.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == FULL_COUNT);
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign dout      = mem_r[rd_ptr_r];

    // Storage array; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: DATA writes queue bytes into a FIFO that
// an FSM serialises LSB first onto txd; STATUS reports overflow/idle/full.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_mmio_if.slave      bus,
    output logic               txd
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] LAST_BAUD = BW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_mmio: CLK_FREQ_HZ/BAUD must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_tx_mmio: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    tx_state_t     state_r, state_s;
    logic [BW-1:0] baud_r, baud_s;
    logic [2:0]    bit_r, bit_s;
    logic [7:0]    shift_r, shift_s;
    logic          txd_r, txd_s;
    logic          ovf_r, ovf_s;
    logic [31:0]   rdata_r, rdata_s;

    logic          last_baud_s;
    logic          pop_s;
    logic          push_s;
    logic          ovf_set_s;
    logic          ovf_clr_s;
    logic          idle_s;
    logic [7:0]    fifo_dout_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          wdata_unused_s;

    assign wdata_unused_s = ^bus.io_wdata[31:8];

    // Full is the registered FIFO count, so a same-cycle pop never rescues a push.
    assign push_s      = bus.io_wr & (bus.io_reg == REG_DATA) & ~fifo_full_s;
    assign ovf_set_s   = bus.io_wr & (bus.io_reg == REG_DATA) & fifo_full_s;
    assign ovf_clr_s   = bus.io_rd & (bus.io_reg == REG_STATUS);
    assign idle_s      = fifo_empty_s & (state_r == S_IDLE);
    assign last_baud_s = (baud_r == LAST_BAUD);

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .din   (bus.io_wdata[7:0]),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Frame sequencing: next state, baud/bit counters, shift register and FIFO pop.
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        pop_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                baud_s = {BW{1'b0}};
                bit_s  = 3'd0;
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_s = fifo_dout_s;
                    state_s = S_START;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                if (last_baud_s) begin
                    baud_s  = {BW{1'b0}};
                    bit_s   = 3'd0;
                    state_s = S_DATA;
                end else begin
                    baud_s = baud_r + BW'(1);
                end
            end
            S_DATA: begin
                if (last_baud_s) begin
                    baud_s  = {BW{1'b0}};
                    shift_s = {1'b0, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        bit_s   = 3'd0;
                        state_s = S_STOP;
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_r + BW'(1);
                end
            end
            S_STOP: begin
                if (last_baud_s) begin
                    baud_s = {BW{1'b0}};
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shift_s = fifo_dout_s;
                        state_s = S_START;
                    end else begin
                        state_s = S_IDLE;
                    end
                end else begin
                    baud_s = baud_r + BW'(1);
                end
            end
            default: begin
                state_s = S_IDLE;
                baud_s  = {BW{1'b0}};
                bit_s   = 3'd0;
            end
        endcase
    end

    // Line level is decoded from the next state so the txd flop lines up with it.
    always_comb begin
        txd_s = 1'b1;
        case (state_s)
            S_START: txd_s = 1'b0;
            S_DATA:  txd_s = shift_s[0];
            default: txd_s = 1'b1;
        endcase
    end

    // Read data mux and sticky overflow; a same-cycle overflow beats the read clear.
    always_comb begin
        rdata_s = rdata_r;
        ovf_s   = ovf_r;
        if (bus.io_rd) begin
            if (bus.io_reg == REG_STATUS) begin
                rdata_s = status_word(ovf_r, idle_s, fifo_full_s);
            end else begin
                rdata_s = 32'h0000_0000;
            end
        end else begin
            rdata_s = rdata_r;
        end
        if (ovf_set_s) begin
            ovf_s = 1'b1;
        end else if (ovf_clr_s) begin
            ovf_s = 1'b0;
        end else begin
            ovf_s = ovf_r;
        end
    end

    // State, counters, line flop and register-file state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            baud_r  <= {BW{1'b0}};
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            txd_r   <= 1'b1;
            ovf_r   <= 1'b0;
            rdata_r <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            txd_r   <= txd_s;
            ovf_r   <= ovf_s;
            rdata_r <= rdata_s;
        end
    end

    assign txd          = txd_r;
    assign bus.io_rdata = rdata_r;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio at 4 clocks per bit and a 4-entry FIFO.
module tb_uart_tx_mmio;
    import uart_pkg::*;

    logic clk;
    logic reset;
    logic txd;
    int   checks;
    int   errors;

    uart_tx_mmio_if bus ();

    uart_tx_mmio #(
        .CLK_FREQ_HZ (40),
        .BAUD        (10),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .txd   (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic sel, input logic [31:0] d);
        bus.io_wr    = 1'b1;
        bus.io_reg   = sel;
        bus.io_wdata = d;
        step();
        bus.io_wr    = 1'b0;
        bus.io_wdata = 32'h0000_0000;
    endtask

    task automatic bus_read(input logic sel, output logic [31:0] d);
        bus.io_rd  = 1'b1;
        bus.io_reg = sel;
        step();
        bus.io_rd  = 1'b0;
        d = bus.io_rdata;
    endtask

    task automatic count_lows(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (txd !== 1'b1) lows++;
        end
    endtask

    // Receives one frame: waits (bounded) for a start bit, then samples mid-bit.
    task automatic rx_frame(output logic [7:0] b, output int waited, output logic start_ok,
                            output logic stop_bit, output logic timed_out);
        waited    = 0;
        timed_out = 1'b0;
        start_ok  = 1'b0;
        stop_bit  = 1'b0;
        b         = 8'h00;
        while (txd !== 1'b0 && waited < 400) begin
            step();
            waited++;
        end
        if (txd !== 1'b0) begin
            timed_out = 1'b1;
        end else begin
            repeat (2) step();
            start_ok = (txd === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (4) step();
                b[i] = txd;
            end
            repeat (4) step();
            stop_bit = txd;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset        = 1'b1;
        bus.io_wr    = 1'b0;
        bus.io_rd    = 1'b0;
        bus.io_reg   = REG_DATA;
        bus.io_wdata = 32'h0000_0000;
        #3;
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
        checks++;
        if (bus.io_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.io_rdata); end
        repeat (3) step();
        reset = 1'b0;
        step();
        bus_read(REG_STATUS, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL reset_status: got %h expected 2", d); end
    endtask

    task automatic test_single_frame();
        logic [31:0] d;
        logic [9:0]  fr;
        int          bad;
        fr = {1'b1, 8'h55, 1'b0};
        bus_read(REG_STATUS, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL single_status_pre: got %h expected 2", d); end
        bus_write(REG_DATA, 32'hFFFF_FF55);
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL single_latency: got %b expected 1 one cycle after write", txd); end
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            checks++;
            if (txd !== fr[k/4]) begin
                errors++;
                bad++;
                if (bad < 4) $display("FAIL single_txd[%0d]: got %b expected %b", k, txd, fr[k/4]);
            end
        end
        repeat (3) step();
        bus_read(REG_STATUS, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL single_status_post: got %h expected 2", d); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b0, b1;
        int         w0, w1;
        logic       s0, s1, p0, p1, t0, t1;
        bus_write(REG_DATA, 32'h0000_00A3);
        bus_write(REG_DATA, 32'h0000_000F);
        rx_frame(b0, w0, s0, p0, t0);
        rx_frame(b1, w1, s1, p1, t1);
        checks++;
        if (t0 || t1) begin errors++; $display("FAIL b2b_timeout: got %b%b expected 00", t0, t1); end
        checks++;
        if (b0 !== 8'hA3) begin errors++; $display("FAIL b2b_byte0: got %h expected a3", b0); end
        checks++;
        if (b1 !== 8'h0F) begin errors++; $display("FAIL b2b_byte1: got %h expected 0f", b1); end
        checks++;
        if (w1 !== 2) begin errors++; $display("FAIL b2b_gap: got %0d expected 2 samples from mid-stop to next start", w1); end
        checks++;
        if ({s0, p0, s1, p1} !== 4'b1111) begin errors++; $display("FAIL b2b_framing: got %b expected 1111", {s0, p0, s1, p1}); end
        repeat (4) step();
    endtask

    task automatic test_overflow();
        logic [7:0]  got [5];
        int          wt [5];
        logic        so [5], sp [5], to [5];
        logic [31:0] st, d;
        int          lows;
        fork
            begin
                for (int i = 0; i < 5; i++) rx_frame(got[i], wt[i], so[i], sp[i], to[i]);
            end
            begin
                for (int j = 0; j < 6; j++) bus_write(REG_DATA, 32'(8'h11 * (j + 1)));
                bus_read(REG_STATUS, st);
            end
        join
        checks++;
        if (st !== 32'h5) begin errors++; $display("FAIL ovf_status: got %h expected 5", st); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (to[i] || got[i] !== 8'(8'h11 * (i + 1)) || !so[i] || !sp[i]) begin
                errors++;
                $display("FAIL ovf_frame%0d: got %h (timeout %b) expected %h", i, got[i], to[i], 8'(8'h11 * (i + 1)));
            end
            if (i > 0) begin
                checks++;
                if (wt[i] !== 2) begin errors++; $display("FAIL ovf_gap%0d: got %0d expected 2", i, wt[i]); end
            end
        end
        count_lows(50, lows);
        checks++;
        if (lows !== 0) begin errors++; $display("FAIL ovf_dropped_sent: got %0d low cycles expected 0", lows); end
        bus_read(REG_STATUS, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL ovf_status_after: got %h expected 2", d); end
    endtask

    task automatic test_wr_rd_same_cycle();
        logic [31:0] d;
        for (int j = 0; j < 5; j++) bus_write(REG_DATA, 32'(8'hC1 + j));
        bus.io_wr    = 1'b1;
        bus.io_rd    = 1'b1;
        bus.io_reg   = REG_DATA;
        bus.io_wdata = 32'h0000_0099;
        step();
        bus.io_wr    = 1'b0;
        bus.io_rd    = 1'b0;
        bus.io_wdata = 32'h0000_0000;
        checks++;
        if (bus.io_rdata !== 32'h0) begin errors++; $display("FAIL wrrd_data_read: got %h expected 0", bus.io_rdata); end
        bus_read(REG_STATUS, d);
        checks++;
        if (d !== 32'h5) begin errors++; $display("FAIL wrrd_status: got %h expected 5", d); end
        bus_read(REG_STATUS, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL wrrd_ovf_cleared: got %h expected 1", d); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        int          lows;
        #1 reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        bus_write(REG_DATA, 32'h0000_00A5);
        bus_write(REG_DATA, 32'h0000_003C);
        repeat (17) step();
        checks++;
        if (txd !== 1'b0) begin errors++; $display("FAIL midrst_bit3: got %b expected 0", txd); end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL midrst_txd: got %b expected 1", txd); end
        step();
        #1 reset = 1'b0;
        step();
        bus_read(REG_STATUS, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL midrst_status: got %h expected 2", d); end
        count_lows(60, lows);
        checks++;
        if (lows !== 0) begin errors++; $display("FAIL midrst_residual: got %0d low cycles expected 0", lows); end
    endtask

    task automatic test_status_write();
        logic [31:0] d;
        int          lows;
        bus_write(REG_STATUS, 32'h0000_00FF);
        count_lows(20, lows);
        checks++;
        if (lows !== 0) begin errors++; $display("FAIL stwr_txd: got %0d low cycles expected 0", lows); end
        bus_read(REG_STATUS, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL stwr_status: got %h expected 2", d); end
        bus_read(REG_DATA, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL data_read: got %h expected 0", d); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_wr_rd_same_cycle();
        test_reset_mid_frame();
        test_status_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
